// File: rtl/cpu_ad48_pkg.sv
// Shared cpu_ad48 definitions: DMEM geometry and master identifiers.
package cpu_ad48_pkg;

   localparam int DMEM_DW  = 48;
   localparam int DMEM_AW  = 7;
   localparam int STARVE_W = 4;

   typedef enum logic {
      MST_CPU = 1'b0,
      MST_AUX = 1'b1
   } mst_id_t;

   // Saturating increment used by the starvation guard.
   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] val,
                                                    input logic [STARVE_W-1:0] lim);
      return (val >= lim) ? lim : val + 1'b1;
   endfunction

endpackage

// File: rtl/cpu_ad48_dmem_arb_prio.sv
// Fixed-priority grant logic for the DMEM arbiter with a starvation guard on the aux master.
module cpu_ad48_dmem_arb_prio
   import cpu_ad48_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt;
   logic                starved;

   assign starved = (starve_cnt == SMAX);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (resetn) begin
         if (req1 && (!req0 || starved)) begin
            gnt1 = 1'b1;
         end else if (req0) begin
            gnt0 = 1'b1;
         end
      end
   end

   // Counts consecutive denials of a waiting aux request.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (!req1 || gnt1) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= sat_inc(starve_cnt, SMAX);
      end
   end

endmodule

// File: rtl/cpu_ad48_dmem_arb.sv
// Two-master arbiter for the cpu_ad48 single-port DMEM with 1-cycle read return steering.
// Optional grant/conflict statistics counters: CPU_AD48_DMEM_ARB_STATS_EN.
module cpu_ad48_dmem_arb
   import cpu_ad48_pkg::*;
#(
   parameter int AW         = DMEM_AW,
   parameter int DW         = DMEM_DW,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef CPU_AD48_DMEM_ARB_STATS_EN
   ,
   output logic [31:0]   stat_gnt0,
   output logic [31:0]   stat_gnt1,
   output logic [31:0]   stat_conflict
`endif
);

   logic    gnt0;
   logic    gnt1;
   logic    rd_pend;
   mst_id_t rd_tag;
   logic    load_gnt;

   cpu_ad48_dmem_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk    (clk),
      .resetn (resetn),
      .req0   (m0_req),
      .req1   (m1_req),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   assign m0_gnt = gnt0;
   assign m1_gnt = gnt1;

   always_comb begin
      mem_en    = gnt0 | gnt1;
      mem_we    = 1'b0;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      if (gnt1) begin
         mem_we    = m1_we;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
      end else if (gnt0) begin
         mem_we    = m0_we;
      end
   end

   assign load_gnt = mem_en & ~mem_we;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_pend <= 1'b0;
         rd_tag  <= MST_CPU;
      end else begin
         rd_pend <= load_gnt;
         if (load_gnt) begin
            rd_tag <= gnt1 ? MST_AUX : MST_CPU;
         end
      end
   end

   // Gating with resetn drops a read whose return cycle falls inside reset.
   assign m0_rvalid = resetn & rd_pend & (rd_tag == MST_CPU);
   assign m1_rvalid = resetn & rd_pend & (rd_tag == MST_AUX);
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

`ifdef CPU_AD48_DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stat_gnt0     <= '0;
         stat_gnt1     <= '0;
         stat_conflict <= '0;
      end else begin
         if (gnt0) begin
            stat_gnt0 <= stat_gnt0 + 32'd1;
         end
         if (gnt1) begin
            stat_gnt1 <= stat_gnt1 + 32'd1;
         end
         if (m0_req && m1_req) begin
            stat_conflict <= stat_conflict + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cpu_ad48_dmem_arb.sv
// Self-checking bench for cpu_ad48_dmem_arb: directed vector table, reset corner cases, random traffic.
module tb_cpu_ad48_dmem_arb;

   localparam int AW = 7;
   localparam int DW = 48;
   localparam int STARVE_MAX = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
`ifdef CPU_AD48_DMEM_ARB_STATS_EN
   logic [31:0]   stat_gnt0, stat_gnt1, stat_conflict;
`endif

   always #5 clk = ~clk;

   cpu_ad48_dmem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef CPU_AD48_DMEM_ARB_STATS_EN
      , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
   );

   function automatic logic [DW-1:0] init_val(int i);
      return DW'((i + 1) * 100);
   endfunction

   // Synchronous RAM with 1-cycle read latency.
   logic [DW-1:0] ram [128];
   logic          load_ram = 1'b0;
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   typedef struct {
      logic rn, r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
      logic r1, w1;     logic [AW-1:0] a1; logic [DW-1:0] d1;
      logic eg0, eg1, erv0, erv1; logic [DW-1:0] erd;
   } vec_t;

   function automatic vec_t mkv(int r0, int w0, int a0, longint d0,
                                int r1, int w1, int a1, longint d1,
                                int g0, int g1, int rv0, int rv1, longint rd);
      vec_t v;
      v.rn = 1'b1;
      v.r0 = (r0 != 0); v.w0 = (w0 != 0); v.a0 = AW'(a0); v.d0 = DW'(d0);
      v.r1 = (r1 != 0); v.w1 = (w1 != 0); v.a1 = AW'(a1); v.d1 = DW'(d1);
      v.eg0 = (g0 != 0); v.eg1 = (g1 != 0); v.erv0 = (rv0 != 0); v.erv1 = (rv1 != 0);
      v.erd = DW'(rd);
      return v;
   endfunction

   int errors = 0;
   int checks = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level reference: denial count, shadow memory, one outstanding read.
   logic [DW-1:0] mm [128];
   int            denials = 0;
   bit            pend = 0;
   bit            ptag = 0;
   logic [DW-1:0] pdata = '0;
   bit            exp_g0, exp_g1;

   task automatic apply(input vec_t v);
      resetn = v.rn;
      m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
   endtask

   task automatic run_cycle(input bit use_tab, input vec_t v);
      bit ev0, ev1;
      @(negedge clk);
      exp_g1 = resetn && m1_req && (!m0_req || denials >= STARVE_MAX);
      exp_g0 = resetn && m0_req && !exp_g1;
      ev0 = resetn && pend && !ptag;
      ev1 = resetn && pend && ptag;
      chk1("m0_gnt", m0_gnt, exp_g0);
      chk1("m1_gnt", m1_gnt, exp_g1);
      chk1("m0_rvalid", m0_rvalid, ev0);
      chk1("m1_rvalid", m1_rvalid, ev1);
      if (ev0) chkw("m0_rdata", m0_rdata, pdata);
      if (ev1) chkw("m1_rdata", m1_rdata, pdata);
      chk1("mem_en", mem_en, exp_g0 || exp_g1);
      if (exp_g1) begin
         chk1("mem_we", mem_we, m1_we);
         chkw("mem_addr", 48'(mem_addr), 48'(m1_addr));
         if (m1_we) chkw("mem_wdata", mem_wdata, m1_wdata);
      end else if (exp_g0) begin
         chk1("mem_we", mem_we, m0_we);
         chkw("mem_addr", 48'(mem_addr), 48'(m0_addr));
         if (m0_we) chkw("mem_wdata", mem_wdata, m0_wdata);
      end else begin
         chk1("mem_we_idle", mem_we, 1'b0);
      end
      if (use_tab) begin
         chk1("tab_gnt0", m0_gnt, v.eg0);
         chk1("tab_gnt1", m1_gnt, v.eg1);
         chk1("tab_rvalid0", m0_rvalid, v.erv0);
         chk1("tab_rvalid1", m1_rvalid, v.erv1);
         if (v.erv0) chkw("tab_rdata0", m0_rdata, v.erd);
         if (v.erv1) chkw("tab_rdata1", m1_rdata, v.erd);
      end
      @(posedge clk);
      pend = 0;
      if (!resetn) begin
         denials = 0;
      end else begin
         if (!m1_req || exp_g1) denials = 0;
         else if (denials < STARVE_MAX) denials++;
         if (exp_g0) begin
            if (m0_we) mm[m0_addr] = m0_wdata;
            else begin pend = 1; ptag = 0; pdata = mm[m0_addr]; end
         end
         if (exp_g1) begin
            if (m1_we) mm[m1_addr] = m1_wdata;
            else begin pend = 1; ptag = 1; pdata = mm[m1_addr]; end
         end
      end
      #1;
   endtask

   vec_t tab[$];
   vec_t idle_v;
   vec_t rst_v;

   initial begin
      bit            p0, p1;
      logic [63:0]   rnd;
      vec_t          v;

      for (int i = 0; i < 128; i++) mm[i] = init_val(i);
      idle_v = mkv(0,0,0,0, 0,0,0,0, 0,0,0,0,0);
      rst_v = idle_v;
      rst_v.rn = 1'b0;
      apply(rst_v);
      load_ram = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) run_cycle(1'b1, rst_v);
      load_ram = 1'b0;

      // Directed table: single-master traffic, interleaved loads, continuous contention.
      tab.push_back(mkv(1,1,4,12345, 0,0,0,0, 1,0, 0,0,0));
      tab.push_back(mkv(1,0,4,0,     0,0,0,0, 1,0, 0,0,0));
      tab.push_back(mkv(0,0,0,0,     0,0,0,0, 0,0, 1,0,12345));
      tab.push_back(mkv(0,0,0,0,     1,0,0,0, 0,1, 0,0,0));
      tab.push_back(mkv(0,0,0,0,     1,0,1,0, 0,1, 0,1,100));
      tab.push_back(mkv(0,0,0,0,     0,0,0,0, 0,0, 0,1,200));
      tab.push_back(mkv(1,0,2,0,     0,0,0,0, 1,0, 0,0,0));
      tab.push_back(mkv(0,0,0,0,     1,0,3,0, 0,1, 1,0,300));
      tab.push_back(mkv(0,0,0,0,     0,0,0,0, 0,0, 0,1,400));
      for (int k = 0; k < 10; k++) begin
         bit g1, pg1;
         g1  = (k % 5 == 4);
         pg1 = (k > 0) && ((k - 1) % 5 == 4);
         tab.push_back(mkv(1,0,5,0, 1,0,6,0, !g1, g1,
                           (k > 0) && !pg1, pg1, pg1 ? 700 : 600));
      end
      tab.push_back(mkv(0,0,0,0, 0,0,0,0, 0,0, 0,1,700));
      foreach (tab[i]) begin
         apply(tab[i]);
         run_cycle(1'b1, tab[i]);
      end

      // Reset while an aux load is in flight; a store attempted during reset must not land.
      v = mkv(0,0,0,0, 1,0,0,0, 0,1, 0,0,0);
      apply(v); run_cycle(1'b1, v);
      v = mkv(1,1,7,777, 0,0,0,0, 0,0, 0,0,0);
      v.rn = 1'b0;
      apply(v); run_cycle(1'b1, v);
      apply(idle_v); run_cycle(1'b1, idle_v);
      chk1("post_rst_mem_en", mem_en, 1'b0);
      v = mkv(1,0,7,0, 0,0,0,0, 1,0, 0,0,0);
      apply(v); run_cycle(1'b1, v);
      v = mkv(0,0,0,0, 0,0,0,0, 0,0, 1,0,800);
      apply(v); run_cycle(1'b1, v);
      for (int k = 0; k < 5; k++) begin
         v = mkv(1,1,9,k, 1,1,10,k, k != 4, k == 4, 0,0,0);
         apply(v); run_cycle(1'b1, v);
      end

      // Random traffic with held requests and occasional resets.
      p0 = 0; p1 = 0;
      apply(idle_v);
      for (int i = 0; i < 600; i++) begin
         resetn = ($urandom_range(0, 49) != 0);
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = AW'($urandom_range(0, 15));
            rnd = {$urandom, $urandom}; m0_wdata = rnd[DW-1:0];
         end
         if (!p1 && $urandom_range(0, 3) != 0) begin
            p1 = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = AW'($urandom_range(0, 15));
            rnd = {$urandom, $urandom}; m1_wdata = rnd[DW-1:0];
         end
         m0_req = p0; m1_req = p1;
         run_cycle(1'b0, idle_v);
         if (exp_g0) p0 = 0;
         if (exp_g1) p1 = 0;
      end

`ifdef CPU_AD48_DMEM_ARB_STATS_EN
      apply(rst_v); run_cycle(1'b0, rst_v);
      v = mkv(1,0,11,0, 1,0,12,0, 0,0,0,0,0);
      for (int k = 0; k < 10; k++) begin
         apply(v); run_cycle(1'b0, v);
      end
      chkw("stat_conflict", 48'(stat_conflict), 48'd10);
      chkw("stat_gnt0", 48'(stat_gnt0), 48'd8);
      chkw("stat_gnt1", 48'(stat_gnt1), 48'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
